// File: rtl/nx_axi4s_pkg.sv
// Nexus AXI4-stream slot format, shared by the
// host-side packer and the FPGA-side unpacking bridge.
package nx_axi4s_pkg;

  localparam int NX_MSG_WIDTH   = 31;
  localparam int SLOT_WIDTH     = 32;
  localparam int SLOT_VALID_BIT = 31;

  function automatic int slot_count(
    input int data_width
  );
    return data_width / SLOT_WIDTH;
  endfunction

  function automatic logic [SLOT_WIDTH-1:0] make_slot(
    input logic [NX_MSG_WIDTH-1:0] msg
  );
    logic [SLOT_WIDTH-1:0] s;
    s = '0;
    s[SLOT_VALID_BIT] = 1'b1;
    s[NX_MSG_WIDTH-1:0] = msg;
    return s;
  endfunction

endpackage

// File: rtl/nx_axi4s_packer.sv
// Packs 31-bit Nexus messages into AXI4-stream beats,
// closing beats when full, on flush or on idle timeout.
module nx_axi4s_packer
  import nx_axi4s_pkg::*;
#(
  parameter int AXI4_DATA_WIDTH = 128,
  parameter int IDLE_TIMEOUT    = 16,
  parameter int MAX_BURST       = 64
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [NX_MSG_WIDTH-1:0]    nx_data_i,
  input  logic                       nx_valid_i,
  output logic                       nx_ready_o,
  input  logic                       flush_i,
  output logic [AXI4_DATA_WIDTH-1:0] axi4s_tdata_o,
  output logic                       axi4s_tlast_o,
  output logic                       axi4s_tvalid_o,
  input  logic                       axi4s_tready_i,
  output logic                       idle_o
);

  localparam int SLOTS = slot_count(AXI4_DATA_WIDTH);
  localparam int CW = $clog2(SLOTS + 1);
  localparam int TW = (IDLE_TIMEOUT > 0) ?
                      $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  localparam logic [CW-1:0] FULL   = CW'(SLOTS);
  localparam logic [TW-1:0] TO_MAX = TW'(IDLE_TIMEOUT);
  localparam logic [BW-1:0] B_MAX  = BW'(MAX_BURST);

  logic [NX_MSG_WIDTH-1:0] acc_q [SLOTS];
  logic [NX_MSG_WIDTH-1:0] acc_n [SLOTS];
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_n;
  logic [TW-1:0] to_q;
  logic [BW-1:0] burst_q;
  logic          pend_q;
  logic          pend_last_q;

  logic [AXI4_DATA_WIDTH-1:0] tdata_q;
  logic [AXI4_DATA_WIDTH-1:0] beat_n;
  logic tlast_q;
  logic tvalid_q;

  logic accept;
  logic drain;
  logic out_free;
  logic to_hit;
  logic close_now;
  logic close_last;
  logic load;
  logic load_last;

  assign nx_ready_o = (cnt_q < FULL) & !pend_q;
  assign accept     = nx_valid_i & nx_ready_o;
  assign drain      = tvalid_q & axi4s_tready_i;
  assign out_free   = !tvalid_q | drain;

  assign to_hit = (IDLE_TIMEOUT != 0) &&
                  (to_q == TO_MAX) &&
                  (cnt_q != '0);

  // Beat image always reflects the accumulator
  // including this cycle's accepted message.
  always_comb begin
    cnt_n  = cnt_q + CW'(accept);
    beat_n = '0;
    for (int k = 0; k < SLOTS; k++) begin
      acc_n[k] = acc_q[k];
      if (accept && cnt_q == CW'(k))
        acc_n[k] = nx_data_i;
      if (CW'(k) < cnt_n)
        beat_n[k*SLOT_WIDTH +: SLOT_WIDTH] =
          make_slot(acc_n[k]);
    end
  end

  always_comb begin
    close_now = !pend_q & (
      (cnt_n == FULL) |
      (flush_i & ((cnt_n != '0) | (burst_q != '0))) |
      to_hit);
    close_last = flush_i | to_hit |
                 ((burst_q + BW'(1)) == B_MAX);
    load = out_free & (close_now | pend_q);
    load_last = pend_q ? (pend_last_q | flush_i)
                       : close_last;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < SLOTS; k++)
        acc_q[k] <= '0;
      cnt_q       <= '0;
      to_q        <= '0;
      burst_q     <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      tdata_q     <= '0;
      tlast_q     <= 1'b0;
      tvalid_q    <= 1'b0;
    end else begin
      for (int k = 0; k < SLOTS; k++)
        acc_q[k] <= acc_n[k];

      if (load) begin
        tdata_q  <= beat_n;
        tlast_q  <= load_last;
        tvalid_q <= 1'b1;
      end else if (drain) begin
        tvalid_q <= 1'b0;
      end

      if (load)
        cnt_q <= '0;
      else
        cnt_q <= cnt_n;

      // A closed beat that cannot move waits here;
      // a flush meanwhile turns it into a burst end.
      if (load) begin
        pend_q <= 1'b0;
      end else if (close_now) begin
        pend_q      <= 1'b1;
        pend_last_q <= close_last;
      end else if (pend_q && flush_i) begin
        pend_last_q <= 1'b1;
      end

      if (close_now)
        burst_q <= close_last ? '0 : burst_q + BW'(1);
      else if (pend_q && flush_i)
        burst_q <= '0;

      if (accept || flush_i || close_now || load)
        to_q <= '0;
      else if (cnt_q != '0 && to_q != TO_MAX)
        to_q <= to_q + TW'(1);
    end
  end

  assign axi4s_tdata_o  = tdata_q;
  assign axi4s_tlast_o  = tlast_q;
  assign axi4s_tvalid_o = tvalid_q;
  assign idle_o = (cnt_q == '0) & !tvalid_q & !pend_q;

endmodule
